// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline control: load-use, branch, exception, mul/div occupancy and halt
// handling, driving buffer hold/flush, PC hold and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W     = 4,
  parameter int unsigned MD_CYCLES = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_muldiv,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_halt,
  input  logic             ex_exc,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             exc_redirect,
  output logic             md_busy,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned MD_CNT_W = 5;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MD_WAIT = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                load_use;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_RUN;
      md_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    exc_redirect = 1'b0;
    md_busy      = 1'b0;
    halted       = 1'b0;
    if (reset) begin
      unique case (state_q)
        S_RUN: begin
          if (ex_exc) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            exc_redirect = 1'b1;
          end else if (ex_halt) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_hold    = 1'b1;
            state_d    = S_HALT;
          end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
          end else if (id_muldiv) begin
            // Let the mul/div advance into ID/EX this cycle, then freeze around it.
            state_d  = S_MD_WAIT;
            md_cnt_d = MD_CNT_W'(MD_CYCLES - 1);
          end
        end
        S_MD_WAIT: begin
          md_busy = 1'b1;
          if (ex_exc) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            exc_redirect = 1'b1;
            md_cnt_d     = '0;
            state_d      = S_RUN;
          end else if (md_cnt_q != '0) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_flush = 1'b1;
            md_cnt_d    = md_cnt_q - MD_CNT_W'(1);
          end else begin
            state_d = S_RUN;
          end
        end
        S_HALT: begin
          halted     = 1'b1;
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_flush = 1'b1;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // Saturating count of PC-hold cycles for performance debug.
  always_comb begin
    stall_d = stall_q;
    if (pc_hold && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized check of pipeline_hazard_ctrl against a rule-level
// reference model of the pipeline control behaviour.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_W     = 4;
  localparam int unsigned MD_CYCLES = 16;
  localparam int unsigned CNT_W     = 6;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  localparam int M_RUN  = 0;
  localparam int M_MD   = 1;
  localparam int M_HALT = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             id_uses_rs, id_uses_rt, id_muldiv;
  logic             ex_mem_read, ex_branch_taken, ex_halt, ex_exc;
  logic             pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush;
  logic             exmem_flush, exc_redirect, md_busy, halted;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int m_mode, m_elapsed, m_stall;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .MD_CYCLES(MD_CYCLES), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_muldiv(id_muldiv), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt), .ex_exc(ex_exc),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_hold(idex_hold), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .exc_redirect(exc_redirect), .md_busy(md_busy), .halted(halted),
    .stall_cycles(stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    reset = 1'b1;
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_muldiv = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_halt = 1'b0; ex_exc = 1'b0;
  endtask

  task automatic random_inputs();
    reset           = ($urandom_range(0, 49) != 0);
    id_rs           = REG_W'($urandom_range(0, 3));
    id_rt           = REG_W'($urandom_range(0, 3));
    ex_rd           = REG_W'($urandom_range(0, 3));
    id_uses_rs      = 1'($urandom_range(0, 1));
    id_uses_rt      = 1'($urandom_range(0, 1));
    ex_mem_read     = 1'($urandom_range(0, 1));
    id_muldiv       = ($urandom_range(0, 7) == 0);
    ex_branch_taken = ($urandom_range(0, 5) == 0);
    ex_exc          = ($urandom_range(0, 15) == 0);
    ex_halt         = ($urandom_range(0, 39) == 0);
  endtask

  // One clock: derive the expected controls from the rules, compare mid-cycle,
  // then advance the model across the rising edge.
  task automatic cycle(input string tag);
    logic [8:0] e;   // pc_hold ifid_hold ifid_flush idex_hold idex_flush exmem_flush exc_redirect md_busy halted
    bit hz;
    int nmode, nel, nst;
    e = '0; nmode = m_mode; nel = m_elapsed;
    hz = ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    if (!reset) begin
      nmode = M_RUN; nel = 0;
    end else if (m_mode == M_RUN) begin
      if (ex_exc)               e = 9'b001011100;
      else if (ex_halt)         begin e = 9'b101010000; nmode = M_HALT; end
      else if (ex_branch_taken) e = 9'b001010000;
      else if (hz)              e = 9'b110010000;
      else if (id_muldiv)       begin nmode = M_MD; nel = 1; end
    end else if (m_mode == M_MD) begin
      if (ex_exc)                        begin e = 9'b001011110; nmode = M_RUN; nel = 0; end
      else if (m_elapsed < MD_CYCLES)    begin e = 9'b110101010; nel = m_elapsed + 1; end
      else                               begin e = 9'b000000010; nmode = M_RUN; nel = 0; end
    end else begin
      e = 9'b110010001;
    end
    @(negedge clock);
    check({tag, "/ctrl"}, 32'({pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush,
                               exmem_flush, exc_redirect, md_busy, halted}), 32'(e));
    check({tag, "/stall"}, 32'(stall_cycles), 32'(m_stall));
    if (!reset)                           nst = 0;
    else if (e[8] && m_stall < CNT_MAX)   nst = m_stall + 1;
    else                                  nst = m_stall;
    @(posedge clock);
    #1;
    m_mode = nmode; m_elapsed = nel; m_stall = nst;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0; ex_exc = 1'b1; ex_halt = 1'b1;
    @(posedge clock);
    #1;
    m_mode = M_RUN; m_elapsed = 0; m_stall = 0;
    cycle("rst0");
    cycle("rst1");
    clear_inputs();
    cycle("idle");

    // Load-use on rs, then the same with r0, then via rt
    ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_uses_rs = 1'b1;
    cycle("lu_rs");
    ex_rd = 4'd0; id_rs = 4'd0;
    cycle("lu_r0");
    clear_inputs();
    cycle("post_lu");
    ex_mem_read = 1'b1; ex_rd = 4'd5; id_rt = 4'd5; id_uses_rt = 1'b1; id_rs = 4'd5;
    cycle("lu_rt");
    clear_inputs();

    // Branch beats a coincident load-use and mul/div
    ex_mem_read = 1'b1; ex_rd = 4'd2; id_rs = 4'd2; id_uses_rs = 1'b1;
    ex_branch_taken = 1'b1; id_muldiv = 1'b1;
    cycle("br_lu");
    clear_inputs();
    cycle("post_br");

    // Full mul/div with hazard/branch/halt noise that must be ignored
    id_muldiv = 1'b1;
    cycle("md_issue");
    clear_inputs();
    for (int i = 0; i < MD_CYCLES; i++) begin
      ex_branch_taken = 1'($urandom_range(0, 1));
      ex_halt         = 1'($urandom_range(0, 1));
      ex_mem_read = 1'b1; ex_rd = 4'd1; id_rs = 4'd1; id_uses_rs = 1'b1;
      cycle("md_wait");
    end
    clear_inputs();
    cycle("md_after");

    // Exception on the 5th wait cycle
    id_muldiv = 1'b1;
    cycle("md2_issue");
    clear_inputs();
    for (int i = 0; i < 4; i++) cycle("md2_wait");
    ex_exc = 1'b1;
    cycle("md2_exc");
    clear_inputs();
    cycle("md2_after");

    // Halt (with branch) persists, ignores exceptions, saturates the counter
    ex_halt = 1'b1; ex_branch_taken = 1'b1;
    cycle("halt_issue");
    clear_inputs();
    for (int i = 0; i < 70; i++) begin
      ex_exc  = 1'($urandom_range(0, 1));
      ex_halt = 1'($urandom_range(0, 1));
      cycle("halted");
    end
    clear_inputs();
    reset = 1'b0;
    cycle("halt_rst");
    clear_inputs();
    cycle("post_halt");

    for (int i = 0; i < 400; i++) begin
      random_inputs();
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central pipeline control unit for the 4-stage-buffer processor pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It detects load-use hazards, taken branches, exceptions, multi-cycle multiply/divide occupancy and halt. It drives the hold and flush controls of the pipeline buffers and the PC hold. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_W, 4, register-address width.
MD_CYCLES, 16, total cycles a mul/div occupies EX (valid range 2..31).
CNT_W, 16, width of stall-cycle counter.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
id_rs  in  REG_W  rs field of the instruction in IF/ID.
id_rt  in  REG_W  rt field of the instruction in IF/ID.
id_uses_rs  in  1  IF/ID instruction reads rs.
id_uses_rt  in  1  IF/ID instruction reads rt.
id_muldiv  in  1  IF/ID instruction is mul/div.
ex_mem_read  in  1  ID/EX instruction is a load.
ex_rd  in  REG_W  destination register of the ID/EX instruction.
ex_branch_taken  in  1  branch resolved taken in EX this cycle.
ex_halt  in  1  halt instruction in EX.
ex_exc  in  1  exception (e.g. overflow) raised in EX.
pc_hold  out  1  PC keeps its value.
ifid_hold  out  1  hold IF/ID buffer.
ifid_flush  out  1  flush IF/ID buffer.
idex_hold  out  1  hold ID/EX buffer.
idex_flush  out  1  flush ID/EX buffer.
exmem_flush  out  1  flush EX/MEM buffer.
exc_redirect  out  1  PC loads exception vector.
md_busy  out  1  mul/div in progress.
halted  out  1  core halted.
stall_cycles  out  CNT_W  saturating count of cycles with pc_hold=1.

Behaviour:
- States: RUN, MD_WAIT, HALT. There is a down-counter md_cnt (5 bits).
- Control outputs are combinational from state and inputs, so stalls take effect in the same cycle. State, md_cnt and stall_cycles are registered.
- Reset (reset=0 at a rising edge): state<=RUN, md_cnt<=0, stall_cycles<=0.
- While reset=0, all control outputs are forced to 0 combinationally. stall_cycles reads 0 after the first reset edge.
- Load-use hazard: ex_mem_read & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)). Register 0 never hazards.
- RUN, evaluated in priority order:
  1. ex_exc: ifid_flush=idex_flush=exmem_flush=1, exc_redirect=1; stay RUN.
  2. ex_halt: ifid_flush=idex_flush=1, pc_hold=1; next state HALT.
  3. ex_branch_taken: ifid_flush=idex_flush=1. A coincident load-use hazard or id_muldiv is ignored.
  4. Load-use: pc_hold=ifid_hold=1, idex_flush=1 (one-bubble stall). It re-evaluates each cycle and naturally clears next cycle.
  5. id_muldiv: no holds this cycle, so the mul/div advances into ID/EX. Next state MD_WAIT, md_cnt<=MD_CYCLES-1.
  6. Otherwise: all outputs 0.
- MD_WAIT, md_busy=1:
  - ex_exc: flush all three buffers, exc_redirect=1, md_cnt<=0, next RUN.
  - md_cnt!=0: pc_hold=ifid_hold=idex_hold=1, exmem_flush=1, md_cnt<=md_cnt-1. Hazard, branch and halt inputs are ignored.
  - md_cnt==0: no holds, md_busy still 1, next RUN. The mul/div thus spends exactly MD_CYCLES cycles in EX.
- HALT: halted=1, pc_hold=ifid_hold=1, idex_flush=1 every cycle; in-flight EX/MEM and MEM/WB drain. Only reset leaves HALT, and ex_exc is ignored.
- hold and flush are never both 1 on the same buffer.
- stall_cycles increments on every clock with pc_hold=1 (post-reset) and saturates at all-ones.

Test Plan:
- Reset: hold reset=0 for 2 clocks with ex_exc=1 and ex_halt=1 → all outputs 0, stall_cycles=0, state RUN after release.
- Load-use: ex_mem_read=1, ex_rd=3, id_rs=3, id_uses_rs=1 → pc_hold=ifid_hold=idex_flush=1 that cycle. Repeat with ex_rd=0 → no stall. Expected stall_cycles=1.
- Branch vs load-use: ex_branch_taken=1 plus a load-use hazard in the same cycle → ifid_flush=idex_flush=1, pc_hold=0, stall_cycles unchanged.
- Mul/div with MD_CYCLES=16: id_muldiv=1 in RUN → next 15 cycles have pc_hold=idex_hold=exmem_flush=1 and md_busy=1. The 16th cycle has md_busy=1 with no holds, then RUN. stall_cycles=15.
- Exception mid mul/div: ex_exc=1 on the 5th MD_WAIT cycle → all three flushes and exc_redirect=1, next cycle RUN with md_busy=0.
- Halt: ex_halt=1 (with ex_branch_taken=1) → halted=1 from the next cycle onward, pc_hold=1 indefinitely, ex_exc ignored. reset=0 returns to RUN.
